// File: rtl/pipeline_pkg.sv
// Shared pipeline types and encodings: ResultSrc codes, the "no write" RegWrite
// value and the packed D->E register record with its bubble constant.
package pipeline_pkg;

    localparam int PIPE_XLEN = 32;

    localparam logic [1:0] RS_ALU  = 2'd0;
    localparam logic [1:0] RS_LOAD = 2'd1;
    localparam logic [1:0] RS_PC4  = 2'd2;

    localparam logic [2:0] RW_NONE = 3'd0;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic [2:0]           reg_write;
        logic [1:0]           result_src;
        logic                 mem_write;
        logic [3:0]           alu_control;
        logic                 alu_src;
        logic                 branch;
        logic                 jump;
        logic [PIPE_XLEN-1:0] rd1;
        logic [PIPE_XLEN-1:0] rd2;
        logic [PIPE_XLEN-1:0] imm_ext;
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] pc_plus4;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

    // Bubble keeps the datapath payload of the previous entry (it is don't-care)
    // and takes every architecturally visible control/register field from the
    // bubble constant, so the datapath registers need no reset/clear muxing.
    function automatic id_ex_t make_bubble(input id_ex_t prev);
        id_ex_t b;
        b            = prev;
        b.valid      = ID_EX_BUBBLE.valid;
        b.rs1        = ID_EX_BUBBLE.rs1;
        b.rs2        = ID_EX_BUBBLE.rs2;
        b.rd         = ID_EX_BUBBLE.rd;
        b.reg_write  = ID_EX_BUBBLE.reg_write;
        b.result_src = ID_EX_BUBBLE.result_src;
        b.mem_write  = ID_EX_BUBBLE.mem_write;
        b.branch     = ID_EX_BUBBLE.branch;
        b.jump       = ID_EX_BUBBLE.jump;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use detector: a load in E whose destination matches either
// source field of the instruction in D forces a one-cycle F/D hold.
module load_use_detect #(
    parameter logic [1:0] RS_LOAD = 2'b01
) (
    input  logic       i_valid_e,
    input  logic [1:0] i_result_src_e,
    input  logic [2:0] i_reg_write_e,
    input  logic [4:0] i_rd_e,
    input  logic       i_valid_d,
    input  logic [4:0] i_rs1_d,
    input  logic [4:0] i_rs2_d,
    output logic       o_load_use_stall
);
    import pipeline_pkg::*;

    logic w_load_in_e;
    logic w_src_match;

    assign w_load_in_e = i_valid_e
                       & (i_result_src_e == RS_LOAD)
                       & (i_reg_write_e != RW_NONE)
                       & (i_rd_e != 5'd0);

    // Deliberately ignores whether D actually reads rs1/rs2: a spurious stall
    // costs one cycle, a missed one corrupts data.
    assign w_src_match = (i_rs1_d == i_rd_e) | (i_rs2_d == i_rd_e);

    assign o_load_use_stall = w_load_in_e & i_valid_d & w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion, x0 write
// suppression and a saturating bubble-cycle counter.
module id_ex_stage #(
    parameter int         XLEN    = 32,
    parameter int         CNT_W   = 16,
    parameter logic [1:0] RS_LOAD = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_StallE,
    input  logic             i_FlushE,
    input  logic             i_ValidD,
    input  logic [4:0]       i_Rs1D,
    input  logic [4:0]       i_Rs2D,
    input  logic [4:0]       i_RdD,
    input  logic [2:0]       i_RegWriteD,
    input  logic [1:0]       i_ResultSrcD,
    input  logic             i_MemWriteD,
    input  logic [3:0]       i_ALUControlD,
    input  logic             i_ALUSrcD,
    input  logic             i_BranchD,
    input  logic             i_JumpD,
    input  logic [XLEN-1:0]  i_RD1D,
    input  logic [XLEN-1:0]  i_RD2D,
    input  logic [XLEN-1:0]  i_ImmExtD,
    input  logic [XLEN-1:0]  i_PCD,
    input  logic [XLEN-1:0]  i_PCPlus4D,
    output logic             o_ValidE,
    output logic [4:0]       o_Rs1E,
    output logic [4:0]       o_Rs2E,
    output logic [4:0]       o_RdE,
    output logic [2:0]       o_RegWriteE,
    output logic [1:0]       o_ResultSrcE,
    output logic             o_MemWriteE,
    output logic [3:0]       o_ALUControlE,
    output logic             o_ALUSrcE,
    output logic             o_BranchE,
    output logic             o_JumpE,
    output logic [XLEN-1:0]  o_RD1E,
    output logic [XLEN-1:0]  o_RD2E,
    output logic [XLEN-1:0]  o_ImmExtE,
    output logic [XLEN-1:0]  o_PCE,
    output logic [XLEN-1:0]  o_PCPlus4E,
    output logic             o_LoadUseStall,
    output logic [CNT_W-1:0] o_BubbleCount
);
    import pipeline_pkg::*;

    id_ex_t            r_e;
    id_ex_t            w_d;
    id_ex_t            w_e_next;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic              w_load_use;
    logic              w_bubble;
    logic              w_cnt_sat;

    load_use_detect #(
        .RS_LOAD (RS_LOAD)
    ) u_load_use_detect (
        .i_valid_e        (r_e.valid),
        .i_result_src_e   (r_e.result_src),
        .i_reg_write_e    (r_e.reg_write),
        .i_rd_e           (r_e.rd),
        .i_valid_d        (i_ValidD),
        .i_rs1_d          (i_Rs1D),
        .i_rs2_d          (i_Rs2D),
        .o_load_use_stall (w_load_use)
    );

    always_comb begin
        w_d             = ID_EX_BUBBLE;
        w_d.valid       = i_ValidD;
        w_d.rs1         = i_Rs1D;
        w_d.rs2         = i_Rs2D;
        w_d.rd          = i_RdD;
        // x0 is never a forwarding source, so downstream can trust any nonzero RegWrite.
        w_d.reg_write   = (i_RdD == 5'd0) ? RW_NONE : i_RegWriteD;
        w_d.result_src  = i_ResultSrcD;
        w_d.mem_write   = i_MemWriteD;
        w_d.alu_control = i_ALUControlD;
        w_d.alu_src     = i_ALUSrcD;
        w_d.branch      = i_BranchD;
        w_d.jump        = i_JumpD;
        w_d.rd1         = i_RD1D;
        w_d.rd2         = i_RD2D;
        w_d.imm_ext     = i_ImmExtD;
        w_d.pc          = i_PCD;
        w_d.pc_plus4    = i_PCPlus4D;
    end

    assign w_bubble  = i_FlushE | w_load_use;
    assign w_cnt_sat = &r_bubble_cnt;

    // An empty D slot is loaded like a bubble but is not counted as one.
    always_comb begin
        w_e_next = w_d;
        if (w_bubble || !i_ValidD) begin
            w_e_next = make_bubble(r_e);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_e          <= ID_EX_BUBBLE;
            r_bubble_cnt <= '0;
        end else if (!i_StallE) begin
            r_e <= w_e_next;
            if (w_bubble && !w_cnt_sat) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign o_ValidE       = r_e.valid;
    assign o_Rs1E         = r_e.rs1;
    assign o_Rs2E         = r_e.rs2;
    assign o_RdE          = r_e.rd;
    assign o_RegWriteE    = r_e.reg_write;
    assign o_ResultSrcE   = r_e.result_src;
    assign o_MemWriteE    = r_e.mem_write;
    assign o_ALUControlE  = r_e.alu_control;
    assign o_ALUSrcE      = r_e.alu_src;
    assign o_BranchE      = r_e.branch;
    assign o_JumpE        = r_e.jump;
    assign o_RD1E         = r_e.rd1;
    assign o_RD2E         = r_e.rd2;
    assign o_ImmExtE      = r_e.imm_ext;
    assign o_PCE          = r_e.pc;
    assign o_PCPlus4E     = r_e.pc_plus4;
    assign o_LoadUseStall = w_load_use;
    assign o_BubbleCount  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an abstract model of the E register checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallE, FlushE, ValidD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [2:0]  RegWriteD;
    logic [1:0]  ResultSrcD;
    logic        MemWriteD;
    logic [3:0]  ALUControlD;
    logic        ALUSrcD, BranchD, JumpD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;

    logic        ValidE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [2:0]  RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic [3:0]  ALUControlE;
    logic        ALUSrcE, BranchE, JumpE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic        LoadUseStall;
    logic [15:0] BubbleCount;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .i_StallE(StallE), .i_FlushE(FlushE), .i_ValidD(ValidD),
        .i_Rs1D(Rs1D), .i_Rs2D(Rs2D), .i_RdD(RdD), .i_RegWriteD(RegWriteD),
        .i_ResultSrcD(ResultSrcD), .i_MemWriteD(MemWriteD), .i_ALUControlD(ALUControlD),
        .i_ALUSrcD(ALUSrcD), .i_BranchD(BranchD), .i_JumpD(JumpD),
        .i_RD1D(RD1D), .i_RD2D(RD2D), .i_ImmExtD(ImmExtD), .i_PCD(PCD), .i_PCPlus4D(PCPlus4D),
        .o_ValidE(ValidE), .o_Rs1E(Rs1E), .o_Rs2E(Rs2E), .o_RdE(RdE), .o_RegWriteE(RegWriteE),
        .o_ResultSrcE(ResultSrcE), .o_MemWriteE(MemWriteE), .o_ALUControlE(ALUControlE),
        .o_ALUSrcE(ALUSrcE), .o_BranchE(BranchE), .o_JumpE(JumpE),
        .o_RD1E(RD1E), .o_RD2E(RD2E), .o_ImmExtE(ImmExtE), .o_PCE(PCE), .o_PCPlus4E(PCPlus4E),
        .o_LoadUseStall(LoadUseStall), .o_BubbleCount(BubbleCount)
    );

    // Abstract model: what E must hold, written straight from the behavioural rules.
    bit          m_valid = 0;
    logic [4:0]  m_rs1 = 0, m_rs2 = 0, m_rd = 0;
    logic [2:0]  m_rw = 0;
    logic [1:0]  m_rsrc = 0;
    logic        m_mw = 0, m_alusrc = 0, m_br = 0, m_j = 0;
    logic [3:0]  m_alu = 0;
    logic [31:0] m_rd1 = 0, m_rd2 = 0, m_imm = 0, m_pc = 0, m_pc4 = 0;
    int          m_cnt = 0;

    function automatic bit exp_lus();
        return m_valid && (m_rsrc == 2'd1) && (m_rw != 3'd0) && (m_rd != 5'd0) && ValidD
               && ((Rs1D == m_rd) || (Rs2D == m_rd));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 0; m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_rw <= 0; m_rsrc <= 0;
            m_mw <= 0; m_alu <= 0; m_alusrc <= 0; m_br <= 0; m_j <= 0;
            m_rd1 <= 0; m_rd2 <= 0; m_imm <= 0; m_pc <= 0; m_pc4 <= 0; m_cnt <= 0;
        end else if (StallE) begin
            // everything held
        end else if (FlushE || exp_lus() || !ValidD) begin
            m_valid <= 0; m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_rw <= 0; m_rsrc <= 0;
            m_mw <= 0; m_br <= 0; m_j <= 0;
            if ((FlushE || exp_lus()) && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end else begin
            m_valid <= 1; m_rs1 <= Rs1D; m_rs2 <= Rs2D; m_rd <= RdD;
            m_rw <= (RdD == 5'd0) ? 3'd0 : RegWriteD;
            m_rsrc <= ResultSrcD; m_mw <= MemWriteD; m_alu <= ALUControlD;
            m_alusrc <= ALUSrcD; m_br <= BranchD; m_j <= JumpD;
            m_rd1 <= RD1D; m_rd2 <= RD2D; m_imm <= ImmExtD; m_pc <= PCD; m_pc4 <= PCPlus4D;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ctrl", {ValidE, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, MemWriteE,
                           ALUControlE, ALUSrcE, BranchE, JumpE},
                          {m_valid, m_rs1, m_rs2, m_rd, m_rw, m_rsrc, m_mw,
                           m_alu, m_alusrc, m_br, m_j});
            check("rd1", RD1E, m_rd1);
            check("rd2", RD2E, m_rd2);
            check("imm", ImmExtE, m_imm);
            check("pc",  {PCE, PCPlus4E}, {m_pc, m_pc4});
            check("lus", LoadUseStall, exp_lus());
            check("cnt", BubbleCount, m_cnt[15:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [2:0] rw, input logic [1:0] rsrc, input logic jmp,
                         input logic [31:0] pc);
        ValidD = 1; Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = rw; ResultSrcD = rsrc;
        MemWriteD = 0; ALUControlD = pc[5:2]; ALUSrcD = pc[2]; BranchD = 0; JumpD = jmp;
        RD1D = pc ^ 32'hA5A5_0000; RD2D = pc ^ 32'h0000_5A5A; ImmExtD = pc + 32'd16;
        PCD = pc; PCPlus4D = pc + 32'd4;
    endtask

    initial begin
        rst_n = 0; StallE = 1; FlushE = 1; ValidD = 1;
        Rs1D = 3; Rs2D = 4; RdD = 5; RegWriteD = 2; ResultSrcD = 1; MemWriteD = 1;
        ALUControlD = 4'hA; ALUSrcD = 1; BranchD = 1; JumpD = 1;
        RD1D = 32'h11; RD2D = 32'h22; ImmExtD = 32'h33; PCD = 32'h44; PCPlus4D = 32'h48;
        tick();
        cmp_en = 1;
        tick();
        $display("reset: ValidE=%0d RdE=%0d count=%0d", ValidE, RdE, BubbleCount);
        check("rst_valid", ValidE, 0);
        check("rst_rd", RdE, 0);
        check("rst_pc", PCE, 0);
        check("rst_cnt", BubbleCount, 0);
        check("rst_lus", LoadUseStall, 0);

        rst_n = 1; StallE = 0; FlushE = 0;
        set_d(5'd1, 5'd2, 5'd5, 3'd1, 2'd0, 0, 32'h100);      // add x5,x1,x2
        tick();
        $display("plain load: RdE=%0d Rs1E=%0d Rs2E=%0d RegWriteE=%0d", RdE, Rs1E, Rs2E, RegWriteE);
        check("add_rd", RdE, 5);
        check("add_rs", {Rs1E, Rs2E}, {5'd1, 5'd2});
        check("add_rw", RegWriteE, 1);
        check("add_valid", ValidE, 1);
        check("add_cnt", BubbleCount, 0);

        set_d(5'd1, 5'd2, 5'd0, 3'd1, 2'd0, 0, 32'h104);      // write to x0
        tick();
        $display("x0 squash: RegWriteE=%0d ValidE=%0d", RegWriteE, ValidE);
        check("x0_rw", RegWriteE, 0);

        set_d(5'd1, 5'd0, 5'd6, 3'd1, 2'd1, 0, 32'h108);      // lw x6,0(x1)
        tick();
        set_d(5'd3, 5'd6, 5'd7, 3'd1, 2'd0, 0, 32'h10C);      // add x7,x3,x6
        #1;
        $display("load-use: LoadUseStall=%0d", LoadUseStall);
        check("lu_stall", LoadUseStall, 1);
        tick();
        check("lu_bubble", {ValidE, RegWriteE}, 0);
        check("lu_cleared", LoadUseStall, 0);
        check("lu_cnt", BubbleCount, 1);
        tick();
        $display("consumer entered: RdE=%0d ValidE=%0d", RdE, ValidE);
        check("lu_consumer", {ValidE, RdE}, {1'b1, 5'd7});

        set_d(5'd1, 5'd2, 5'd9, 3'd1, 2'd0, 0, 32'h110);
        StallE = 1; FlushE = 1;
        repeat (3) tick();
        $display("stall+flush held: RdE=%0d count=%0d", RdE, BubbleCount);
        check("sf_hold", {ValidE, RdE, PCE}, {1'b1, 5'd7, 32'h10C});
        check("sf_cnt", BubbleCount, 1);
        StallE = 0;
        tick();
        FlushE = 0;
        $display("flush after stall: ValidE=%0d count=%0d", ValidE, BubbleCount);
        check("sf_bubble", ValidE, 0);
        check("sf_cnt2", BubbleCount, 2);

        ValidD = 0;
        tick();
        $display("empty D: ValidE=%0d count=%0d", ValidE, BubbleCount);
        check("nv_cnt", BubbleCount, 2);

        set_d(5'd2, 5'd0, 5'd8, 3'd1, 2'd1, 0, 32'h200);      // lw x8
        tick();
        set_d(5'd8, 5'd0, 5'd10, 3'd1, 2'd0, 0, 32'h204);
        StallE = 1;
        tick();
        $display("stall+load-use: RdE=%0d LoadUseStall=%0d", RdE, LoadUseStall);
        check("slu_hold", {ValidE, RdE}, {1'b1, 5'd8});
        check("slu_lus", LoadUseStall, 1);
        StallE = 0;
        tick();
        check("slu_cnt", BubbleCount, 3);
        tick();

        set_d(5'd0, 5'd0, 5'd1, 3'd1, 2'd2, 1, 32'h300);      // jal x1
        tick();
        set_d(5'd1, 5'd1, 5'd11, 3'd1, 2'd0, 0, 32'h304);
        #1;
        $display("pc4 result in E: LoadUseStall=%0d", LoadUseStall);
        check("jal_nolus", LoadUseStall, 0);
        tick();

        FlushE = 1;
        repeat (65531) tick();
        $display("saturation approach: count=%0h", BubbleCount);
        check("sat_fffe", BubbleCount, 16'hFFFE);
        repeat (3) tick();
        $display("saturation: count=%0h", BubbleCount);
        check("sat_ffff", BubbleCount, 16'hFFFF);
        FlushE = 0;
        tick();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage pipelined RISC-V core.
- Captures decoded control, register numbers, operands and PC from D and presents them to E.
- Its Rs1E, Rs2E, RdE and RegWriteE outputs feed the forwarding unit directly.
- Also detects load-use hazards, inserts bubbles, enforces the x0-never-written rule for forwarding, and counts bubble cycles.

Parameters:
- XLEN, 32, datapath width for operands, immediate and PC.
- CNT_W, 16, width of the saturating bubble counter.
- RS_LOAD, 2'b01, ResultSrc encoding that marks a load (memory result).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- StallE  in  1  hold E register (memory-stage wait); highest priority after reset.
- FlushE  in  1  branch/jump taken in E: load a bubble.
- ValidD  in  1  D holds a real instruction.
- Rs1D, Rs2D, RdD  in  5 each  register numbers from decode.
- RegWriteD  in  3  register-write type; 0 means no write.
- ResultSrcD  in  2  writeback source select.
- MemWriteD  in  1  store enable.
- ALUControlD  in  4  ALU operation.
- ALUSrcD, BranchD, JumpD  in  1 each  control bits.
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  operands, immediate, PC values.
- Every D field above except ValidD has an E-suffixed registered output of the same width.
- ValidE  out  1  E holds a real instruction.
- LoadUseStall  out  1  combinational; asks the hazard unit to hold F and D this cycle.
- BubbleCount  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- Reset (rst_n=0 at edge): all E outputs 0, ValidE=0, BubbleCount=0. Reset mid-stall or mid-flush discards everything. LoadUseStall evaluates to 0 while ValidE=0.
- Priority at each edge: reset > StallE (hold all E fields, counter unchanged) > bubble > load.
- Bubble condition: FlushE=1 or LoadUseStall=1.
- On a bubble:
  - ValidE=0.
  - RegWriteE, MemWriteE, BranchE and JumpE all 0.
  - ResultSrcE=0; Rs1E, Rs2E and RdE=0.
  - Data fields hold their previous values and carry no meaning.
- Load: every E field takes its D value, ValidE=ValidD. If ValidD=0, load as a bubble, but the counter does not increment.
- x0 rule: if RdD=0, RegWriteE loads as 0 regardless of RegWriteD. The forwarding unit may therefore forward on any nonzero RegWrite without checking for x0.
- LoadUseStall = ValidE & (ResultSrcE==RS_LOAD) & (RegWriteE!=0) & (RdE!=0) & ValidD & ((Rs1D==RdE) | (Rs2D==RdE)).
  - Rs fields are compared without checking source usage; the check is deliberately conservative.
  - Latency: a stall lasts exactly one cycle. The load moves to M, the condition clears, and the consumer then enters E with the load value available via W forwarding.
- StallE=1 together with FlushE=1: the hold wins and the flush is not latched. The branch logic must keep FlushE asserted until StallE drops.
- StallE=1 together with LoadUseStall=1: the hold wins. LoadUseStall is still output so F and D stay frozen.
- BubbleCount increments by 1 on every non-reset, non-stalled edge where the bubble condition is true. It saturates at all-ones and never wraps.
- No combinational path exists from any D input to any E output. LoadUseStall depends only on E state, ValidD, Rs1D and Rs2D.

Decomposition:
- Shared package pipeline_pkg holds:
  - ResultSrc encodings (RS_ALU=0, RS_LOAD=1, RS_PC4=2).
  - The RegWrite "none" constant.
  - A packed struct id_ex_t bundling all E fields, so the bubble value is a single constant ID_EX_BUBBLE.
- One natural sub-module: load_use_detect, purely combinational, producing LoadUseStall. The register, priority logic and counter stay in id_ex_stage.

Test Plan:
- Reset: rst_n=0 for 2 cycles with ValidD=1 and all inputs nonzero -> all E outputs 0, ValidE=0, BubbleCount=0, LoadUseStall=0.
- Plain load: D = add x5,x1,x2 (RdD=5, RegWriteD=3'b001) -> next cycle RdE=5, Rs1E=1, Rs2E=2, RegWriteE=1, ValidE=1, BubbleCount unchanged.
- x0 squash: RdD=0, RegWriteD=3'b001 -> RegWriteE=0 after the edge.
- Load-use: E = lw x6 (ResultSrcE=1, RdE=6); D has Rs2D=6 -> LoadUseStall=1 for exactly 1 cycle. The next edge gives ValidE=0 and RegWriteE=0, then the consumer loads. BubbleCount += 1.
- Stall vs flush: StallE=1 and FlushE=1 for 3 cycles -> E fields unchanged and BubbleCount unchanged. When StallE drops with FlushE=1, a bubble is inserted and the count += 1.
- Saturation: preload 0xFFFE, apply FlushE for 3 cycles -> count reads 0xFFFF and stays there.
